// File: rtl/password_lock_param.sv
// Parametrised one-hot keypad lock: DIGITS-key code entry with failure counting, timed lockout,
// admin hard-lock, entry timeout, timed unlock pulse and in-field code reprogramming.
module password_lock_param #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int CNT_W       = 2,
    parameter int UNLOCK_CYC  = 16,
    parameter int LOCKOUT_CYC = 64,
    parameter int TIMEOUT_CYC = 256,
    localparam int KEYS       = 2**DIGIT_W,
    localparam int IDX_W      = $clog2(DIGITS+1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic [KEYS-1:0]           BUTTONS,
    input  logic [DIGITS*DIGIT_W-1:0] CODE_IN,
    input  logic                      CODE_LOAD,
    input  logic                      ADMIN_CLR,
    output logic                      UNLOCK,
    output logic                      ALARM,
    output logic                      ADMIN_LOCK,
    output logic [CNT_W-1:0]          FAIL_COUNT,
    output logic [IDX_W-1:0]          DIGIT_IDX
);

    localparam int T_MAX0 = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int T_MAX  = (T_MAX0 > TIMEOUT_CYC) ? T_MAX0 : TIMEOUT_CYC;
    localparam int TW     = $clog2(T_MAX+1);
    localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_TRIES);

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, LOCKOUT, ADMIN} state_t;

    state_t                      state;
    logic [KEYS-1:0]             prev_btn;
    logic [DIGITS*DIGIT_W-1:0]   code;
    logic                        programmed;
    logic                        mism;
    logic [TW-1:0]               timer;
    logic [DIGIT_W-1:0]          key_val;
    logic [DIGIT_W-1:0]          ref_digit;
    logic                        key_evt;
    logic                        bad;

    always_comb begin
        key_val = '0;
        for (int k = 0; k < KEYS; k++)
            if (BUTTONS[k]) key_val = DIGIT_W'(k);
        ref_digit = '0;
        for (int i = 0; i < DIGITS; i++)
            if (DIGIT_IDX == IDX_W'(i)) ref_digit = code[i*DIGIT_W +: DIGIT_W];
    end

    // Multi-hot changes still count as a keypress, but can never match a digit.
    assign key_evt = (BUTTONS != prev_btn) && (BUTTONS != '0);
    assign bad     = !$onehot(BUTTONS) || (key_val != ref_digit);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            code       <= '0;
            programmed <= 1'b0;
        end else if (CODE_LOAD && (state == OPEN || (state == IDLE && !programmed))) begin
            code       <= CODE_IN;
            programmed <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            prev_btn   <= '0;
            mism       <= 1'b0;
            timer      <= '0;
            UNLOCK     <= 1'b0;
            ALARM      <= 1'b0;
            ADMIN_LOCK <= 1'b0;
            FAIL_COUNT <= '0;
            DIGIT_IDX  <= '0;
        end else begin
            prev_btn <= BUTTONS;
            case (state)
                IDLE: begin
                    if (EN && key_evt) begin
                        mism      <= bad;
                        DIGIT_IDX <= IDX_W'(1);
                        timer     <= '0;
                        state     <= (DIGITS == 1) ? CHECK : ENTRY;
                    end
                end
                ENTRY: begin
                    if (!EN) begin
                        state     <= IDLE;
                        DIGIT_IDX <= '0;
                    end else if (key_evt) begin
                        mism      <= mism | bad;
                        DIGIT_IDX <= DIGIT_IDX + IDX_W'(1);
                        timer     <= '0;
                        if (DIGIT_IDX == IDX_W'(DIGITS-1)) state <= CHECK;
                    end else if (timer == TW'(TIMEOUT_CYC-1)) begin
                        state     <= IDLE;
                        DIGIT_IDX <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                CHECK: begin
                    DIGIT_IDX <= '0;
                    timer     <= '0;
                    if (!mism) begin
                        state      <= OPEN;
                        FAIL_COUNT <= '0;
                    end else if (FAIL_COUNT + CNT_W'(1) == MAX_T) begin
                        state      <= ADMIN;
                        FAIL_COUNT <= MAX_T;
                    end else begin
                        state      <= LOCKOUT;
                        FAIL_COUNT <= FAIL_COUNT + CNT_W'(1);
                    end
                end
                // The first cycle in OPEN/LOCKOUT raises the output, giving a two-edge latency from the last key.
                OPEN: begin
                    if (timer == TW'(UNLOCK_CYC)) begin
                        state  <= IDLE;
                        UNLOCK <= 1'b0;
                    end else begin
                        timer  <= timer + TW'(1);
                        UNLOCK <= 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer == TW'(LOCKOUT_CYC)) begin
                        state <= IDLE;
                        ALARM <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                        ALARM <= 1'b1;
                    end
                end
                ADMIN: begin
                    if (ADMIN_CLR) begin
                        state      <= IDLE;
                        FAIL_COUNT <= '0;
                        ALARM      <= 1'b0;
                        ADMIN_LOCK <= 1'b0;
                    end else begin
                        ALARM      <= 1'b1;
                        ADMIN_LOCK <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_password_lock_param.sv
// Randomised and directed bench for password_lock_param against a queue-based behavioural model.
module tb_password_lock_param;

    localparam int DIGITS = 4, DIGIT_W = 4, MAX_TRIES = 3, CNT_W = 2;
    localparam int UNLOCK_CYC = 16, LOCKOUT_CYC = 64, TIMEOUT_CYC = 256;
    localparam int KEYS = 2**DIGIT_W;
    localparam int IDX_W = $clog2(DIGITS+1);

    logic                      CLK = 1'b0;
    logic                      RST = 1'b0;
    logic                      EN = 1'b0;
    logic [KEYS-1:0]           BUTTONS = '0;
    logic [DIGITS*DIGIT_W-1:0] CODE_IN = '0;
    logic                      CODE_LOAD = 1'b0;
    logic                      ADMIN_CLR = 1'b0;
    logic                      UNLOCK, ALARM, ADMIN_LOCK;
    logic [CNT_W-1:0]          FAIL_COUNT;
    logic [IDX_W-1:0]          DIGIT_IDX;

    password_lock_param #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES), .CNT_W(CNT_W),
        .UNLOCK_CYC(UNLOCK_CYC), .LOCKOUT_CYC(LOCKOUT_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .BUTTONS(BUTTONS), .CODE_IN(CODE_IN),
        .CODE_LOAD(CODE_LOAD), .ADMIN_CLR(ADMIN_CLR), .UNLOCK(UNLOCK), .ALARM(ALARM),
        .ADMIN_LOCK(ADMIN_LOCK), .FAIL_COUNT(FAIL_COUNT), .DIGIT_IDX(DIGIT_IDX)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;
    int n_unlock = 0, n_alarm = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: digits collected in a queue and judged as a whole,
    // timed phases tracked as remaining-cycle countdowns.
    int              code_m [DIGITS];
    bit              prog;
    logic [KEYS-1:0] prev_m;
    int              q[$];
    int              idle_cnt;
    bit              chk_pend;
    int              open_left, lock_left;
    bit              in_admin;
    bit              e_unlock, e_alarm, e_admin;
    int              e_fail;

    function automatic void mreset();
        for (int i = 0; i < DIGITS; i++) code_m[i] = 0;
        prog = 0; prev_m = '0; q.delete(); idle_cnt = 0; chk_pend = 0;
        open_left = 0; lock_left = 0; in_admin = 0;
        e_unlock = 0; e_alarm = 0; e_admin = 0; e_fail = 0;
    endfunction

    function automatic void mstep();
        bit evt, in_open, in_lock, idle, ok;
        int d;
        in_open = open_left > 0;
        in_lock = lock_left > 0;
        idle    = !in_open && !in_lock && !in_admin && !chk_pend && q.size() == 0;
        evt     = (BUTTONS != prev_m) && (BUTTONS != '0);
        d       = $onehot(BUTTONS) ? $clog2(BUTTONS) : -1;
        prev_m  = BUTTONS;
        if (CODE_LOAD && (in_open || (idle && !prog))) begin
            for (int i = 0; i < DIGITS; i++)
                code_m[i] = int'((CODE_IN >> (i*DIGIT_W)) & ((1 << DIGIT_W) - 1));
            prog = 1;
        end
        if (chk_pend) begin
            ok = 1;
            for (int i = 0; i < DIGITS; i++) if (q[i] != code_m[i]) ok = 0;
            q.delete();
            chk_pend = 0;
            if (ok) begin
                e_fail = 0;
                open_left = UNLOCK_CYC + 1;
            end else begin
                e_fail++;
                if (e_fail >= MAX_TRIES) begin
                    e_fail = MAX_TRIES;
                    in_admin = 1;
                end else lock_left = LOCKOUT_CYC + 1;
            end
        end else if (in_open) begin
            open_left--;
            e_unlock = open_left > 0;
        end else if (in_lock) begin
            lock_left--;
            e_alarm = lock_left > 0;
        end else if (in_admin) begin
            if (ADMIN_CLR) begin
                in_admin = 0; e_fail = 0; e_alarm = 0; e_admin = 0;
            end else begin
                e_alarm = 1; e_admin = 1;
            end
        end else if (q.size() == 0) begin
            if (EN && evt) begin
                q.push_back(d);
                idle_cnt = 0;
                if (DIGITS == 1) chk_pend = 1;
            end
        end else begin
            if (!EN) q.delete();
            else if (evt) begin
                q.push_back(d);
                idle_cnt = 0;
                if (q.size() == DIGITS) chk_pend = 1;
            end else begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT_CYC) q.delete();
            end
        end
    endfunction

    always @(posedge CLK) begin
        if (!RST) mreset();
        else mstep();
    end

    task automatic compare_all();
        chk("unlock", int'(UNLOCK), int'(e_unlock));
        chk("alarm", int'(ALARM), int'(e_alarm));
        chk("admin_lock", int'(ADMIN_LOCK), int'(e_admin));
        chk("fail_count", int'(FAIL_COUNT), e_fail);
        chk("digit_idx", int'(DIGIT_IDX), q.size());
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        compare_all();
        if (UNLOCK) n_unlock++;
        if (ALARM) n_alarm++;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press(input logic [KEYS-1:0] b);
        BUTTONS = b;
        cyc();
    endtask

    task automatic enter4(input logic [KEYS-1:0] a, input logic [KEYS-1:0] b,
                          input logic [KEYS-1:0] c, input logic [KEYS-1:0] d);
        press(a); press(b); press(c); press(d);
        BUTTONS = '0;
    endtask

    task automatic do_reset();
        BUTTONS = '0; CODE_LOAD = 0; ADMIN_CLR = 0;
        RST = 0;
        #1;
        mreset();
        chk("rst_unlock", int'(UNLOCK), 0);
        chk("rst_alarm", int'(ALARM), 0);
        chk("rst_admin", int'(ADMIN_LOCK), 0);
        chk("rst_fail", int'(FAIL_COUNT), 0);
        chk("rst_idx", int'(DIGIT_IDX), 0);
        cyc(); cyc();
        RST = 1;
    endtask

    initial begin
        int r, d;
        wait_n(2);
        do_reset();
        EN = 1;

        // 1: program then correct code
        CODE_IN = 16'h3210; CODE_LOAD = 1; cyc(); CODE_LOAD = 0;
        n_unlock = 0;
        enter4(16'h0001, 16'h0002, 16'h0004, 16'h0008);
        cyc();
        chk("t1_lat_n1", int'(UNLOCK), 0);
        cyc();
        chk("t1_lat_n2", int'(UNLOCK), 1);
        wait_n(25);
        chk("t1_unlock_len", n_unlock, UNLOCK_CYC);
        chk("t1_fail", int'(FAIL_COUNT), 0);

        // 2: incomplete entry times out
        n_alarm = 0;
        press(16'h0001); press(16'h0000); press(16'h0004); press(16'h0008);
        BUTTONS = '0; cyc();
        chk("t2_idx3", int'(DIGIT_IDX), 3);
        wait_n(TIMEOUT_CYC + 4);
        chk("t2_idx0", int'(DIGIT_IDX), 0);
        chk("t2_fail", int'(FAIL_COUNT), 0);
        chk("t2_alarm", n_alarm, 0);

        // 3: two wrong codes, keys during lockout ignored
        n_alarm = 0;
        enter4(16'h0001, 16'h0002, 16'h0004, 16'h0001);
        wait_n(4);
        enter4(16'h0001, 16'h0002, 16'h0004, 16'h0008);
        wait_n(70);
        chk("t3_fail1", int'(FAIL_COUNT), 1);
        chk("t3_alarm_len", n_alarm, LOCKOUT_CYC);
        enter4(16'h0001, 16'h0002, 16'h0006, 16'h0008);
        wait_n(70);
        chk("t3_fail2", int'(FAIL_COUNT), 2);

        // 4: admin lock and clear
        enter4(16'h0008, 16'h0004, 16'h0002, 16'h0001);
        wait_n(4);
        chk("t4_admin", int'(ADMIN_LOCK), 1);
        chk("t4_alarm", int'(ALARM), 1);
        chk("t4_fail3", int'(FAIL_COUNT), 3);
        enter4(16'h0001, 16'h0002, 16'h0004, 16'h0008);
        wait_n(5);
        chk("t4_no_unlock", int'(UNLOCK), 0);
        ADMIN_CLR = 1; cyc(); ADMIN_CLR = 0; cyc();
        chk("t4_clr_admin", int'(ADMIN_LOCK), 0);
        chk("t4_clr_fail", int'(FAIL_COUNT), 0);
        enter4(16'h0001, 16'h0002, 16'h0004, 16'h0008);
        wait_n(3);
        chk("t4_unlock", int'(UNLOCK), 1);
        wait_n(20);

        // 5: held key is one event; EN low aborts
        press(16'h0001); press(16'h0001);
        chk("t5_held", int'(DIGIT_IDX), 1);
        press(16'h0002);
        EN = 0; BUTTONS = '0; cyc();
        chk("t5_abort", int'(DIGIT_IDX), 0);
        EN = 1; cyc();

        // 6: reprogram in OPEN, old code fails, new code works, reset mid-OPEN
        enter4(16'h0001, 16'h0002, 16'h0004, 16'h0008);
        wait_n(4);
        CODE_IN = 16'h0123; CODE_LOAD = 1; cyc(); CODE_LOAD = 0;
        wait_n(20);
        enter4(16'h0001, 16'h0002, 16'h0004, 16'h0008);
        wait_n(3);
        chk("t6_old_fail", int'(FAIL_COUNT), 1);
        wait_n(70);
        enter4(16'h0008, 16'h0004, 16'h0002, 16'h0001);
        wait_n(5);
        chk("t6_new_unlock", int'(UNLOCK), 1);
        do_reset();

        // Random traffic
        CODE_IN = 16'($urandom); CODE_LOAD = 1; cyc(); CODE_LOAD = 0;
        for (int it = 0; it < 4000; it++) begin
            r = $urandom_range(0, 199);
            if (r < 100) begin
                if (q.size() < DIGITS && $urandom_range(0, 9) < 8) d = code_m[q.size()];
                else d = $urandom_range(0, KEYS-1);
                press(KEYS'(1) << d);
                if ($urandom_range(0, 1) == 0) press('0);
            end else if (r < 120) press('0);
            else if (r < 126) press(KEYS'($urandom) | KEYS'(3));
            else if (r < 132) begin
                EN = 0; cyc(); EN = 1;
            end else if (r < 140) begin
                CODE_IN = 16'($urandom); CODE_LOAD = 1; cyc(); CODE_LOAD = 0;
            end else if (r < 152) begin
                ADMIN_CLR = 1; cyc(); ADMIN_CLR = 0;
            end else if (r < 160) wait_n(70);
            else if (r < 161) begin
                do_reset();
                EN = 1;
            end else cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
